// File: rtl/mem_pkg.sv
// Shared encodings for the wait-state data memory and its helpers.
package mem_pkg;

    // Access size field.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bytes touched minus one; illegal sizes count as a single byte.
    function automatic logic [1:0] size_last(input logic [1:0] sz);
        case (sz)
            SZ_HALF: size_last = 2'd1;
            SZ_WORD: size_last = 2'd3;
            default: size_last = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/memory_ws_if.sv
// Request/response bundle between the CPU and the wait-state data memory.
interface memory_ws_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output MemRead, MemWrite, size, unsigned_ld, addr, wd,
        input  rd, ready, err, busy
    );

    modport slave (
        input  MemRead, MemWrite, size, unsigned_ld, addr, wd,
        output rd, ready, err, busy
    );
endinterface

// File: rtl/mem_load_align.sv
// Formats four little-endian raw bytes into a sign- or zero-extended load value.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [7:0]  b0_i,
    input  logic [7:0]  b1_i,
    input  logic [7:0]  b2_i,
    input  logic [7:0]  b3_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_ld_i,
    output logic [31:0] rd_o
);

    // Select the loaded width and extend from its MSB unless zero-extension is requested.
    always_comb begin
        rd_o = '0;
        case (size_i)
            SZ_BYTE: rd_o = {{24{~unsigned_ld_i & b0_i[7]}}, b0_i};
            SZ_HALF: rd_o = {{16{~unsigned_ld_i & b1_i[7]}}, b1_i, b0_i};
            default: rd_o = {b3_i, b2_i, b1_i, b0_i};
        endcase
    end

endmodule

// File: rtl/memory_ws.sv
// Byte-addressed little-endian data memory with configurable wait states,
// a one-cycle ready pulse and rejection of misaligned/out-of-range accesses.
module memory_ws
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    memory_ws_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);

    logic [7:0] mem [DEPTH];

    state_t            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [31:0]       rd_q;
    logic              ready_q, err_q, busy_q;

    // Request fields captured at accept.
    logic        op_rd_q, op_wr_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wd_q;

    logic        req;
    logic        cur_rd, cur_wr, cur_uns;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wd;
    logic [32:0] end_addr;
    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic        enter_done_d, err_d, do_read_d, do_write_d;
    logic [31:0] load_d;

    assign req = bus.MemRead | bus.MemWrite;

    // With zero wait states the commit happens on the accept edge itself, so the
    // live inputs are used in IDLE and the latched copy otherwise.
    always_comb begin
        cur_rd   = (state_q == IDLE) ? bus.MemRead     : op_rd_q;
        cur_wr   = (state_q == IDLE) ? bus.MemWrite    : op_wr_q;
        cur_uns  = (state_q == IDLE) ? bus.unsigned_ld : uns_q;
        cur_size = (state_q == IDLE) ? bus.size        : size_q;
        cur_addr = (state_q == IDLE) ? bus.addr        : addr_q;
        cur_wd   = (state_q == IDLE) ? bus.wd          : wd_q;

        enter_done_d = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (wcnt_q == WAIT_LAST));

        end_addr = {1'b0, cur_addr} + 33'(size_last(cur_size));
        err_d = (cur_size == 2'b11) ||
                ((cur_size == SZ_HALF) && cur_addr[0]) ||
                ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00)) ||
                (|end_addr[32:ADDR_W]) ||
                (cur_rd && cur_wr);

        do_read_d  = enter_done_d & cur_rd & ~err_d;
        do_write_d = enter_done_d & cur_wr & ~err_d & rst_n;

        idx0 = cur_addr[ADDR_W-1:0];
        idx1 = idx0 + ADDR_W'(1);
        idx2 = idx0 + ADDR_W'(2);
        idx3 = idx0 + ADDR_W'(3);
    end

    mem_load_align u_align (
        .b0_i          (mem[idx0]),
        .b1_i          (mem[idx1]),
        .b2_i          (mem[idx2]),
        .b3_i          (mem[idx3]),
        .size_i        (cur_size),
        .unsigned_ld_i (cur_uns),
        .rd_o          (load_d)
    );

    // Control FSM with registered handshake outputs and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            op_rd_q <= 1'b0;
            op_wr_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (req) begin
                        op_rd_q <= bus.MemRead;
                        op_wr_q <= bus.MemWrite;
                        uns_q   <= bus.unsigned_ld;
                        size_q  <= bus.size;
                        addr_q  <= bus.addr;
                        wd_q    <= bus.wd;
                        busy_q  <= 1'b1;
                        wcnt_q  <= '0;
                        state_q <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!enter_done_d) wcnt_q <= wcnt_q + 1'b1;
                    else               state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
            if (enter_done_d) begin
                ready_q <= 1'b1;
                err_q   <= err_d;
                if (do_read_d) rd_q <= load_d;
            end
        end
    end

    // Array update on the DONE-entry edge only, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (do_write_d) begin
            mem[idx0] <= cur_wd[7:0];
            if (cur_size != SZ_BYTE) mem[idx1] <= cur_wd[15:8];
            if (cur_size == SZ_WORD) begin
                mem[idx2] <= cur_wd[23:16];
                mem[idx3] <= cur_wd[31:24];
            end
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule
